// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared state type and arbitration mode constants for the Wishbone arbiter
package wb_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   localparam int MODE_FIXED = 0;
   localparam int MODE_RR    = 1;

endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational one-hot winner select, fixed priority or round-robin after i_last
module rr_picker
   import wb_arb_pkg::*;
#(
   parameter int N  = 2,
   parameter int LW = $clog2(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [LW-1:0] i_last,
   input  logic          i_mode,
   output logic [N-1:0]  o_win
);

   // Lowest-index requester wins; in round-robin mode requesters above i_last outrank the wrapped ones
   always_comb begin
      o_win = '0;
      for (int i = N - 1; i >= 0; i--)
         if (i_req[i] && (!i_mode || i <= int'(i_last))) begin
            o_win    = '0;
            o_win[i] = 1'b1;
         end
      for (int i = N - 1; i >= 0; i--)
         if (i_req[i] && i_mode && i > int'(i_last)) begin
            o_win    = '0;
            o_win[i] = 1'b1;
         end
   end

endmodule

// File: rtl/wb_arbiter_n.sv
// wb_arbiter_n: N-master to 1-slave Wishbone arbiter with fixed/round-robin grant and bus timeout
module wb_arbiter_n
   import wb_arb_pkg::*;
#(
   parameter int N_MASTERS = 2,
   parameter int ADDR_W    = 27,
   parameter int DATA_W    = 256,
   parameter int SEL_W     = 32,
   parameter int MODE      = 1,
   parameter int TIMEOUT   = 0
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic [N_MASTERS-1:0]        i_m_cyc,
   input  logic [N_MASTERS-1:0]        i_m_stb,
   input  logic [N_MASTERS-1:0]        i_m_we,
   input  logic [N_MASTERS*ADDR_W-1:0] i_m_adr,
   input  logic [N_MASTERS*DATA_W-1:0] i_m_dat_m,
   input  logic [N_MASTERS*SEL_W-1:0]  i_m_sel,
   output logic [DATA_W-1:0]           o_m_dat_s,
   output logic [N_MASTERS-1:0]        o_m_ack,
   output logic [N_MASTERS-1:0]        o_m_rty,
   output logic                        o_s_cyc,
   output logic                        o_s_stb,
   output logic                        o_s_we,
   output logic [ADDR_W-1:0]           o_s_adr,
   output logic [DATA_W-1:0]           o_s_dat_m,
   output logic [SEL_W-1:0]            o_s_sel,
   input  logic [DATA_W-1:0]           i_s_dat_s,
   input  logic                        i_s_ack,
   input  logic                        i_s_rty,
   output logic [N_MASTERS-1:0]        o_grant
);

   localparam int LW = $clog2(N_MASTERS);
   localparam int TW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

   arb_state_t           r_state;
   logic [N_MASTERS-1:0] r_grant;
   logic [LW-1:0]        r_gidx;
   logic [LW-1:0]        r_last;
   logic [TW-1:0]        r_tmo_cnt;

   logic [N_MASTERS-1:0] w_req;
   logic [N_MASTERS-1:0] w_win;
   logic [LW-1:0]        w_win_idx;
   logic                 w_cyc;
   logic                 w_stb;
   logic                 w_we;
   logic [ADDR_W-1:0]    w_adr;
   logic [DATA_W-1:0]    w_dat;
   logic [SEL_W-1:0]     w_sel;
   logic                 w_busy;
   logic                 w_tmo;
   logic                 w_exit;

   assign w_req = i_m_cyc & i_m_stb;

   rr_picker #(
      .N  (N_MASTERS),
      .LW (LW)
   ) u_picker (
      .i_req  (w_req),
      .i_last (r_last),
      .i_mode (MODE != MODE_FIXED),
      .o_win  (w_win)
   );

   // Binary index of the picked master, remembered as the next round-robin pointer
   always_comb begin
      w_win_idx = '0;
      for (int i = 0; i < N_MASTERS; i++)
         if (w_win[i]) w_win_idx = LW'(i);
   end

   // Route the granted master's request fields; an empty grant yields all zeros, so IDLE is quiet
   always_comb begin
      w_cyc = 1'b0;
      w_stb = 1'b0;
      w_we  = 1'b0;
      w_adr = '0;
      w_dat = '0;
      w_sel = '0;
      for (int i = 0; i < N_MASTERS; i++)
         if (r_grant[i]) begin
            w_cyc = i_m_cyc[i];
            w_stb = i_m_stb[i];
            w_we  = i_m_we[i];
            w_adr = i_m_adr[i*ADDR_W +: ADDR_W];
            w_dat = i_m_dat_m[i*DATA_W +: DATA_W];
            w_sel = i_m_sel[i*SEL_W +: SEL_W];
         end
   end

   assign w_busy = (r_state == BUSY);
   assign w_tmo  = (TIMEOUT != 0) && w_busy && (r_tmo_cnt == TMO_LAST);
   assign w_exit = w_busy && (i_s_ack || i_s_rty || !w_cyc || w_tmo);

   // A timing-out cycle withdraws the bus from the slave while the master is told to retry
   assign o_s_cyc   = w_cyc & ~w_tmo;
   assign o_s_stb   = w_stb & ~w_tmo;
   assign o_s_we    = w_we;
   assign o_s_adr   = w_adr;
   assign o_s_dat_m = w_dat;
   assign o_s_sel   = w_sel;
   assign o_m_dat_s = i_s_dat_s;
   assign o_m_ack   = i_s_ack ? r_grant : '0;
   assign o_m_rty   = (i_s_rty || (w_tmo && !i_s_ack && w_cyc)) ? r_grant : '0;
   assign o_grant   = r_grant;

   // Grant FSM: arbitrate in IDLE, hold the grant until response, abort or timeout
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_state   <= IDLE;
         r_grant   <= '0;
         r_gidx    <= '0;
         r_last    <= LW'(N_MASTERS - 1);
         r_tmo_cnt <= '0;
      end else if (r_state == IDLE) begin
         if (|w_req) begin
            r_state   <= BUSY;
            r_grant   <= w_win;
            r_gidx    <= w_win_idx;
            r_tmo_cnt <= '0;
         end
      end else if (w_exit) begin
         r_state <= IDLE;
         r_grant <= '0;
         r_last  <= r_gidx;
      end else if (r_tmo_cnt != '1)
         r_tmo_cnt <= r_tmo_cnt + 1'b1;

endmodule
